uart_rx_buffer: RTL and testbench

//   Receive-side byte buffer directly downstream of the UART receiver.
//   - Captures each good byte on the receiver's 1-cycle ready pulse into a FIFO.
//   - Discards frames flagged as framing errors and counts them.
//   - Presents bytes to the consumer over a valid/ready handshake, so the consumer may stall.

---
 rtl/uart_rx_buffer_pkg.sv | 10 +
 rtl/uart_sync_fifo.sv | 58 +++++
 rtl/uart_rx_buffer.sv | 79 +++++++
 tb/tb_uart_rx_buffer.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_buffer_pkg.sv
// Shared definitions for the UART receive-side buffer and its FIFO.
package uart_rx_buffer_pkg;

    localparam int UART_DATA_W = 8;

    function automatic logic is_rise(input logic cur, input logic prev);
        return cur & ~prev;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; head entry is read combinationally from memory.
module uart_sync_fifo
    import uart_rx_buffer_pkg::*;
#(
    parameter int WIDTH = UART_DATA_W,
    parameter int DEPTH = 16,
    localparam int ADDR_W = $clog2(DEPTH),
    localparam int CNT_W  = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              pop,
    output logic [WIDTH-1:0]  rd_data,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    logic [WIDTH-1:0]  mem_r [DEPTH];
    logic [ADDR_W-1:0] rd_ptr_r;
    logic [ADDR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              do_push_s;
    logic              do_pop_s;

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign do_pop_s  = pop & ~empty;
    // A push into a full FIFO still lands when the same cycle frees a slot.
    assign do_push_s = push & (~full | do_pop_s);
    assign rd_data   = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Pointer and occupancy tracking
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_r <= {ADDR_W{1'b0}};
            wr_ptr_r <= {ADDR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + ADDR_W'(1);
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + ADDR_W'(1);
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents are not reset
    always_ff @(posedge clk) begin
        if (do_push_s) mem_r[wr_ptr_r] <= wr_data;
    end

endmodule

// File: rtl/uart_rx_buffer.sv
// Receive byte buffer: drops framing-error frames, counts error events, flags overflow.
module uart_rx_buffer
    import uart_rx_buffer_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int ERR_CNT_W = 8,
    localparam int ADDR_W   = $clog2(DEPTH),
    localparam int CNT_W    = ADDR_W + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [UART_DATA_W-1:0] in_data,
    input  logic                   in_ready,
    input  logic                   in_error,
    output logic [UART_DATA_W-1:0] out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CNT_W-1:0]       count,
    output logic                   overflow,
    output logic [ERR_CNT_W-1:0]   err_count,
    input  logic                   clr_status
);

    logic                 push_s;
    logic                 pop_s;
    logic                 full_s;
    logic                 empty_s;
    logic                 drop_s;
    logic                 err_edge_s;
    logic                 in_error_d_r;
    logic                 overflow_r;
    logic [ERR_CNT_W-1:0] err_count_r;

    assign push_s     = in_ready & ~in_error;
    assign out_valid  = ~empty_s;
    assign pop_s      = out_valid & out_ready;
    assign drop_s     = push_s & full_s & ~pop_s;
    assign err_edge_s = is_rise(in_error, in_error_d_r);
    assign overflow   = overflow_r;
    assign err_count  = err_count_r;

    uart_sync_fifo #(
        .WIDTH (UART_DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push_s),
        .wr_data (in_data),
        .pop     (pop_s),
        .rd_data (out_data),
        .count   (count),
        .full    (full_s),
        .empty   (empty_s)
    );

    // Status: a new event in the clearing cycle takes precedence over the clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_error_d_r <= 1'b0;
            overflow_r   <= 1'b0;
            err_count_r  <= {ERR_CNT_W{1'b0}};
        end else begin
            in_error_d_r <= in_error;

            if (drop_s)          overflow_r <= 1'b1;
            else if (clr_status) overflow_r <= 1'b0;
            else                 overflow_r <= overflow_r;

            if (clr_status)
                err_count_r <= err_edge_s ? ERR_CNT_W'(1) : {ERR_CNT_W{1'b0}};
            else if (err_edge_s && (err_count_r != {ERR_CNT_W{1'b1}}))
                err_count_r <= err_count_r + ERR_CNT_W'(1);
            else
                err_count_r <= err_count_r;
        end
    end

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Directed self-checking bench for uart_rx_buffer (DEPTH=16, ERR_CNT_W=8).
module tb_uart_rx_buffer;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_ready;
    logic       in_error;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] count;
    logic       overflow;
    logic [7:0] err_count;
    logic       clr_status;

    int n_cmp = 0;
    int n_err = 0;

    uart_rx_buffer #(.DEPTH(16), .ERR_CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .in_error   (in_error),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .count      (count),
        .overflow   (overflow),
        .err_count  (err_count),
        .clr_status (clr_status)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_byte(input logic [7:0] b);
        in_data  = b;
        in_ready = 1'b1;
        tick();
        in_ready = 1'b0;
    endtask

    task automatic err_pulse(input int cycles);
        in_error = 1'b1;
        repeat (cycles) tick();
        in_error = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1; in_data = 8'h00; in_ready = 1'b0; in_error = 1'b0;
        out_ready = 1'b0; clr_status = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // 1: reset state, then three bytes streamed through
        check("rst_count", 32'(count), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_err", 32'(err_count), 32'd0);
        out_ready = 1'b1;
        in_ready = 1'b1;
        in_data = 8'h41; tick();
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_d41", 32'(out_data), 32'h41);
        check("t1_cnt1", 32'(count), 32'd1);
        in_data = 8'h42; tick();
        check("t1_d42", 32'(out_data), 32'h42);
        in_data = 8'h43; tick();
        check("t1_d43", 32'(out_data), 32'h43);
        check("t1_cnt", 32'(count), 32'd1);
        in_ready = 1'b0; tick();
        check("t1_cnt0", 32'(count), 32'd0);
        check("t1_empty", 32'(out_valid), 32'd0);

        // 2: overfill by one byte, then drain
        out_ready = 1'b0;
        for (int i = 0; i < 17; i++) push_byte(8'(i));
        check("t2_full", 32'(count), 32'd16);
        check("t2_ovf", 32'(overflow), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("t2_drain%0d", i), 32'(out_data), 32'(i));
            tick();
        end
        check("t2_cnt0", 32'(count), 32'd0);
        check("t2_valid0", 32'(out_valid), 32'd0);
        check("t2_ovf_hold", 32'(overflow), 32'd1);
        clr_status = 1'b1; tick(); clr_status = 1'b0;
        check("t2_ovf_clr", 32'(overflow), 32'd0);

        // 3: push and pop together on a full FIFO
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) push_byte(8'(8'h20 + i));
        check("t3_full", 32'(count), 32'd16);
        out_ready = 1'b1;
        push_byte(8'hAA);
        check("t3_cnt", 32'(count), 32'd16);
        check("t3_ovf", 32'(overflow), 32'd0);
        for (int i = 1; i < 16; i++) begin
            check($sformatf("t3_drain%0d", i), 32'(out_data), 32'(8'h20 + i));
            tick();
        end
        check("t3_last", 32'(out_data), 32'hAA);
        tick();
        check("t3_empty", 32'(out_valid), 32'd0);

        // 4: multi-cycle error levels count once; errored byte discarded
        err_pulse(3);
        err_pulse(3);
        in_data = 8'h55; in_ready = 1'b1; in_error = 1'b1; tick();
        in_ready = 1'b0; in_error = 1'b0; tick();
        check("t4_err", 32'(err_count), 32'd3);
        check("t4_cnt", 32'(count), 32'd0);
        check("t4_valid", 32'(out_valid), 32'd0);

        // 5: saturation and clear interaction
        clr_status = 1'b1; tick(); clr_status = 1'b0;
        check("t5_clr0", 32'(err_count), 32'd0);
        for (int i = 0; i < 256; i++) err_pulse(1);
        check("t5_sat", 32'(err_count), 32'd255);
        err_pulse(1);
        check("t5_hold", 32'(err_count), 32'd255);
        clr_status = 1'b1; tick(); clr_status = 1'b0;
        check("t5_clr", 32'(err_count), 32'd0);
        clr_status = 1'b1; in_error = 1'b1; tick();
        clr_status = 1'b0; in_error = 1'b0; tick();
        check("t5_clr_evt", 32'(err_count), 32'd1);

        // 5b: overflow event in the same cycle as clear wins
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) push_byte(8'(8'h60 + i));
        clr_status = 1'b1; push_byte(8'hEE); clr_status = 1'b0;
        check("t5_ovf_win", 32'(overflow), 32'd1);
        check("t5_ovf_cnt", 32'(count), 32'd16);
        check("t5_head", 32'(out_data), 32'h60);

        // 6: reset mid-drain at count 5
        out_ready = 1'b1;
        repeat (11) tick();
        check("t6_cnt5", 32'(count), 32'd5);
        #2 reset = 1'b1;
        #1;
        check("t6_async_cnt", 32'(count), 32'd0);
        tick();
        check("t6_cnt", 32'(count), 32'd0);
        check("t6_valid", 32'(out_valid), 32'd0);
        check("t6_ovf", 32'(overflow), 32'd0);
        check("t6_err", 32'(err_count), 32'd0);
        reset = 1'b0;
        out_ready = 1'b0;
        tick();
        push_byte(8'h77);
        push_byte(8'h78);
        check("t6_first", 32'(out_data), 32'h77);
        check("t6_cnt2", 32'(count), 32'd2);
        out_ready = 1'b1; tick();
        check("t6_second", 32'(out_data), 32'h78);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
